// File: rtl/trade_menu.sv
// Trading menu for the stock game: browse, enter and commit per-stock sells, drive HEX5..HEX0.
// Latency: key press sampled at edge k acts at edge k+3; sold_bus and state change on that same edge.
// No backpressure: key pulses are single-cycle and dropped when the current state ignores them.
module trade_menu #(
    parameter int NUM_STOCKS = 2,
    parameter int MSG_CYCLES = 100_000_000
) (
    input  logic                      CLOCK_50,
    input  logic                      resetn,
    input  logic                      enter,
    input  logic [3:0]                KEY,
    input  logic [9:0]                SW,
    input  logic [12*NUM_STOCKS-1:0]  price_bus,
    input  logic [8*NUM_STOCKS-1:0]   qty_bus,
    input  logic [23:0]               current_cash,
    output logic [8*NUM_STOCKS-1:0]   sold_bus,
    output logic                      exit,
    output logic [6:0]                HEX5,
    output logic [6:0]                HEX4,
    output logic [6:0]                HEX3,
    output logic [6:0]                HEX2,
    output logic [6:0]                HEX1,
    output logic [6:0]                HEX0
);

    localparam int             TW       = (MSG_CYCLES > 1) ? $clog2(MSG_CYCLES) : 1;
    localparam logic [TW-1:0]  T_LOAD   = TW'(MSG_CYCLES - 1);
    localparam logic [3:0]     LAST_IDX = 4'(NUM_STOCKS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_BROWSE = 3'd1;
    localparam logic [2:0] S_ENTRY  = 3'd2;
    localparam logic [2:0] S_SOLD   = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // Letter glyphs, active-low, bit 0 = segment a.
    localparam logic [6:0] G_BLANK = 7'h7F;
    localparam logic [6:0] G_S     = 7'h12;
    localparam logic [6:0] G_O     = 7'h40;
    localparam logic [6:0] G_L     = 7'h47;
    localparam logic [6:0] G_D     = 7'h21;
    localparam logic [6:0] G_E     = 7'h06;
    localparam logic [6:0] G_R     = 7'h2F;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic       unused_sw;
    assign unused_sw = ^SW[9:8];

    logic [2:0]    state, state_n;
    logic [3:0]    idx, idx_n;
    logic [TW-1:0] timer, timer_n;
    logic          exit_n;
    logic          clr_sold, add_sold;
    logic [7:0]    sold_q [NUM_STOCKS];

    // 16-entry views so a 4-bit idx can select without range issues; unused slots read 0.
    logic [11:0] price_a [16];
    logic [7:0]  qty_a   [16];
    logic [7:0]  sold_a  [16];

    for (genvar g = 0; g < 16; g++) begin : g_view
        if (g < NUM_STOCKS) begin : g_on
            assign price_a[g]        = price_bus[12*g +: 12];
            assign qty_a[g]          = qty_bus[8*g +: 8];
            assign sold_a[g]         = sold_q[g];
            assign sold_bus[8*g +: 8] = sold_q[g];
        end else begin : g_off
            assign price_a[g] = '0;
            assign qty_a[g]   = '0;
            assign sold_a[g]  = '0;
        end
    end

    logic [11:0] cur_price;
    logic [7:0]  rem;
    assign cur_price = price_a[idx];
    assign rem       = qty_a[idx] - sold_a[idx];

    // Key front end: 2-flop sync, then registered falling-edge pulse.
    // prev stays 0 until the sync pipe holds real samples, so a key held through reset never fires.
    logic [3:0] sync1, sync2, prev, pulse;
    logic [1:0] settle;

    // Synchronise buttons and form one-cycle press pulses.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync1  <= 4'hF;
            sync2  <= 4'hF;
            prev   <= 4'h0;
            pulse  <= 4'h0;
            settle <= 2'b00;
        end else begin
            sync1  <= KEY;
            sync2  <= sync1;
            settle <= {settle[0], 1'b1};
            prev   <= settle[1] ? sync2 : 4'h0;
            pulse  <= prev & ~sync2;
        end
    end

    // Only the highest-priority pulse survives: cancel > confirm > entry > next.
    logic act_cancel, act_confirm, act_entry, act_next;
    assign act_cancel  = pulse[2];
    assign act_confirm = pulse[3] & ~pulse[2];
    assign act_entry   = pulse[1] & ~pulse[2] & ~pulse[3];
    assign act_next    = pulse[0] & ~pulse[1] & ~pulse[2] & ~pulse[3];

    // Next-state and datapath control for the menu.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        timer_n  = timer;
        exit_n   = 1'b0;
        clr_sold = 1'b0;
        add_sold = 1'b0;
        case (state)
            S_IDLE: begin
                if (enter) begin
                    clr_sold = 1'b1;
                    idx_n    = 4'd0;
                    state_n  = S_BROWSE;
                end
            end
            S_BROWSE: begin
                if (act_cancel) begin
                    clr_sold = 1'b1;
                    idx_n    = 4'd0;
                end else if (act_confirm) begin
                    exit_n  = 1'b1;
                    state_n = S_DONE;
                end else if (act_entry) begin
                    state_n = S_ENTRY;
                end else if (act_next) begin
                    idx_n = (idx == LAST_IDX) ? 4'd0 : idx + 4'd1;
                end
            end
            S_ENTRY: begin
                if (act_cancel) begin
                    clr_sold = 1'b1;
                    idx_n    = 4'd0;
                    state_n  = S_BROWSE;
                end else if (act_confirm) begin
                    timer_n = T_LOAD;
                    if (SW[7:0] <= rem) begin
                        add_sold = 1'b1;
                        state_n  = S_SOLD;
                    end else begin
                        state_n = S_ERR;
                    end
                end else if (act_entry) begin
                    state_n = S_BROWSE;
                end
            end
            S_SOLD, S_ERR: begin
                if (act_cancel) begin
                    clr_sold = 1'b1;
                    idx_n    = 4'd0;
                    timer_n  = '0;
                    state_n  = S_BROWSE;
                end else if (timer == '0) begin
                    state_n = (state == S_SOLD) ? S_BROWSE : S_ENTRY;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            S_DONE: begin
                if (!enter) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            idx   <= 4'd0;
            timer <= '0;
            exit  <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            timer <= timer_n;
            exit  <= exit_n;
        end
    end

    // Per-stock sell accumulators; a commit never exceeds the remaining holding.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_STOCKS; i++) sold_q[i] <= 8'd0;
        end else if (clr_sold) begin
            for (int i = 0; i < NUM_STOCKS; i++) sold_q[i] <= 8'd0;
        end else if (add_sold) begin
            for (int i = 0; i < NUM_STOCKS; i++) begin
                if (idx == 4'(i)) sold_q[i] <= sold_q[i] + SW[7:0];
            end
        end
    end

    // Seven-segment content per state.
    always_comb begin
        HEX5 = G_BLANK;
        HEX4 = G_BLANK;
        HEX3 = G_BLANK;
        HEX2 = G_BLANK;
        HEX1 = G_BLANK;
        HEX0 = G_BLANK;
        case (state)
            S_BROWSE: begin
                HEX5 = hex7(cur_price[11:8]);
                HEX4 = hex7(cur_price[7:4]);
                HEX3 = hex7(cur_price[3:0]);
                HEX2 = hex7(idx);
                HEX1 = hex7(rem[7:4]);
                HEX0 = hex7(rem[3:0]);
            end
            S_ENTRY: begin
                HEX5 = hex7(idx);
                HEX3 = hex7(rem[7:4]);
                HEX2 = hex7(rem[3:0]);
                HEX1 = hex7(SW[7:4]);
                HEX0 = hex7(SW[3:0]);
            end
            S_SOLD: begin
                HEX5 = G_S;
                HEX4 = G_O;
                HEX3 = G_L;
                HEX2 = G_D;
            end
            S_ERR: begin
                HEX5 = G_E;
                HEX4 = G_R;
                HEX3 = G_R;
            end
            S_DONE: begin
                HEX5 = hex7(current_cash[23:20]);
                HEX4 = hex7(current_cash[19:16]);
                HEX3 = hex7(current_cash[15:12]);
                HEX2 = hex7(current_cash[11:8]);
                HEX1 = hex7(current_cash[7:4]);
                HEX0 = hex7(current_cash[3:0]);
            end
            default: ;
        endcase
    end

endmodule
